// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel registered data selector with valid/ready handshakes.
// In fixed mode an external select picks the channel. In round-robin mode a
// rotating pointer arbitrates fairly among the requesting channels. The winner
// is captured into a one-entry output register, tagged with its channel index.
module mux_rr_arb #(
    parameter  int N_CH = 4,
    parameter  int DW   = 4,
    localparam int IW   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [IW-1:0]      sel,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [N_CH-1:0]    in_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [IW-1:0]      out_ch,
    output logic               out_active,
    input  logic               out_ready
);

    // Output register and arbitration pointer
    logic            r_vld_p1;
    logic [DW-1:0]   r_data_p1;
    logic [IW-1:0]   r_ch_p1;
    logic            r_active_p1;
    logic [IW-1:0]   r_rr_ptr;

    // Grant path
    logic              w_ld_ok;
    logic [2*N_CH-1:0] w_req2;
    logic [N_CH-1:0]   w_rot;
    logic              w_rr_hit;
    logic [IW-1:0]     w_rr_idx;
    logic [IW:0]       w_sum;
    logic              w_fix_hit;
    logic              w_hit;
    logic              w_fire;
    logic [IW-1:0]     w_idx;
    logic [IW-1:0]     w_ptr_nxt;
    logic [DW-1:0]     w_data;
    logic [N_CH-1:0]   w_gnt;

    // The output slot is free when empty or being drained this cycle.
    assign w_ld_ok = en & (~r_vld_p1 | out_ready);

    // Rotate the request vector so that bit 0 is the channel at rr_ptr; the
    // first set bit then gives the winner's offset from the pointer.
    assign w_req2 = {in_valid, in_valid};
    assign w_rot  = N_CH'(w_req2 >> r_rr_ptr);

    // Round-robin search: first requester at or after rr_ptr, modulo N_CH.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        w_sum    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_rr_hit && w_rot[k]) begin
                w_rr_hit = 1'b1;
                w_sum    = {1'b0, r_rr_ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N_CH)) begin
                    w_sum = w_sum - (IW+1)'(N_CH);
                end
                w_rr_idx = w_sum[IW-1:0];
            end
        end
    end

    // Fixed select: an out-of-range sel matches no channel and so never grants.
    always_comb begin
        w_fix_hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == IW'(i) && in_valid[i]) begin
                w_fix_hit = 1'b1;
            end
        end
    end

    assign w_hit  = mode ? w_rr_hit : w_fix_hit;
    assign w_idx  = mode ? w_rr_idx : sel;
    assign w_fire = w_ld_ok & w_hit;

    assign w_ptr_nxt = (w_idx == IW'(N_CH - 1)) ? '0 : w_idx + 1'b1;

    // One-hot grant and winner data selection.
    always_comb begin
        w_gnt  = '0;
        w_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_idx == IW'(i)) begin
                w_gnt[i] = w_fire;
                w_data   = in_data[i*DW +: DW];
            end
        end
    end

    assign in_ready = w_gnt;

    // Output stage: load on grant, drop valid on drain without a new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_data_p1   <= '0;
            r_ch_p1     <= '0;
            r_active_p1 <= 1'b0;
        end else if (w_fire) begin
            r_vld_p1    <= 1'b1;
            r_data_p1   <= w_data;
            r_ch_p1     <= w_idx;
            r_active_p1 <= (w_idx != '0);
        end else if (out_ready) begin
            r_vld_p1    <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only on round-robin grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_fire && mode) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    assign out_valid  = r_vld_p1;
    assign out_data   = r_data_p1;
    assign out_ch     = r_ch_p1;
    assign out_active = r_active_p1;

endmodule
